mic_frame_buffer: RTL

//  Consumes the NUM_CH decimated CIC filter outputs of the mic array.
//  On each decimated sample strobe during a record window, it snapshots all

---
 rtl/mic_frame_buffer.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/mic_frame_buffer.sv
// Snapshots all decimated mic channels on a sample strobe and serialises the
// frame through a show-ahead FIFO as a tagged valid/ready word stream.
module mic_frame_buffer #(
    parameter int NUM_CH     = 16,
    parameter int DATA_W     = 16,
    parameter int FIFO_DEPTH = 64,
    parameter int CNT_W      = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_CH*DATA_W-1:0]     ch_data,
    input  logic                         sample_stb,
    input  logic                         rec_en,
    output logic [DATA_W-1:0]            out_data,
    output logic [$clog2(NUM_CH)-1:0]    out_ch,
    output logic                         out_sof,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [CNT_W-1:0]             frame_cnt,
    output logic [CNT_W-1:0]             ovf_cnt,
    output logic                         busy
);

    localparam int CH_W   = $clog2(NUM_CH);
    localparam int AW     = $clog2(FIFO_DEPTH);
    localparam int WORD_W = CH_W + DATA_W;
    localparam logic [AW:0]     DEPTH_C = (AW+1)'(FIFO_DEPTH);
    localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

    typedef enum logic {IDLE, LOAD} state_t;

    state_t                         state_q, state_d;
    logic [NUM_CH-1:0][DATA_W-1:0]  snap_q, snap_d;
    logic [CH_W-1:0]                idx_q, idx_d;
    logic [AW-1:0]                  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]                  rd_ptr_q, rd_ptr_d;
    logic [AW:0]                    count_q, count_d;
    logic [CNT_W-1:0]               frame_cnt_q, frame_cnt_d;
    logic [CNT_W-1:0]               ovf_cnt_q, ovf_cnt_d;
    logic                           out_valid_q, out_valid_d;
    logic [DATA_W-1:0]              out_data_q, out_data_d;
    logic [CH_W-1:0]                out_ch_q, out_ch_d;
    logic                           out_sof_q, out_sof_d;
    logic [WORD_W-1:0]              mem_q [FIFO_DEPTH];

    logic                           push, pop;
    logic [WORD_W-1:0]              wr_word, head;

    always_comb begin
        state_d     = state_q;
        snap_d      = snap_q;
        idx_d       = idx_q;
        frame_cnt_d = frame_cnt_q;
        ovf_cnt_d   = ovf_cnt_q;
        push        = (state_q == LOAD) && (count_q < DEPTH_C);
        pop         = out_valid_q && out_ready;
        wr_word     = {idx_q, snap_q[idx_q]};

        case (state_q)
            IDLE: begin
                if (sample_stb && rec_en) begin
                    snap_d  = ch_data;
                    idx_d   = '0;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                // A strobe while a frame is still serialising is dropped, including on the final edge.
                if (sample_stb && rec_en && (ovf_cnt_q != '1))
                    ovf_cnt_d = ovf_cnt_q + CNT_W'(1);
                if (push) begin
                    idx_d = idx_q + CH_W'(1);
                    if (idx_q == LAST_CH) begin
                        state_d = IDLE;
                        if (frame_cnt_q != '1)
                            frame_cnt_d = frame_cnt_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q + (AW+1)'(push) - (AW+1)'(pop);

        // When the FIFO drains to empty this edge, the word being written becomes the new head.
        if (count_q == (AW+1)'(pop))
            head = wr_word;
        else
            head = mem_q[rd_ptr_d];

        out_valid_d = (count_d != '0);
        out_data_d  = head[DATA_W-1:0];
        out_ch_d    = head[WORD_W-1 -: CH_W];
        out_sof_d   = out_valid_d && (out_ch_d == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            snap_q      <= '0;
            idx_q       <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            frame_cnt_q <= '0;
            ovf_cnt_q   <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            out_sof_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            snap_q      <= snap_d;
            idx_q       <= idx_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            frame_cnt_q <= frame_cnt_d;
            ovf_cnt_q   <= ovf_cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            out_sof_q   <= out_sof_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem_q[wr_ptr_q] <= wr_word;
    end

    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;
    assign out_sof   = out_sof_q;
    assign out_valid = out_valid_q;
    assign frame_cnt = frame_cnt_q;
    assign ovf_cnt   = ovf_cnt_q;
    assign busy      = (state_q != IDLE);

endmodule
